// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: fetch FSM encodings, NOP and base opcodes.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned OPC_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

    localparam logic [OPC_W-1:0] OPC_LOAD   = 7'h03;
    localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'h13;
    localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'h17;
    localparam logic [OPC_W-1:0] OPC_STORE  = 7'h23;
    localparam logic [OPC_W-1:0] OPC_OP     = 7'h33;
    localparam logic [OPC_W-1:0] OPC_LUI    = 7'h37;
    localparam logic [OPC_W-1:0] OPC_BRANCH = 7'h63;
    localparam logic [OPC_W-1:0] OPC_JALR   = 7'h67;
    localparam logic [OPC_W-1:0] OPC_JAL    = 7'h6F;
    localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'h73;

    function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter with next-PC select; misaligned targets are rejected and flagged.
module pc_reg
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_en,
    input  logic        sel_target,
    input  logic [31:0] pc_target,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misalign_err
);

    logic [31:0] pc_q, pc_d;
    logic        misalign_q, misalign_d;
    logic [31:0] next_pc_c;

    assign pc_plus4     = pc_q + 32'd4;
    assign pc           = pc_q;
    assign misalign_err = misalign_q;

    always_comb begin
        pc_d       = pc_q;
        misalign_d = misalign_q;
        next_pc_c  = sel_target ? pc_target : pc_plus4;
        if (load_en) begin
            if (is_word_aligned(next_pc_c)) begin
                pc_d = next_pc_c;
            end else begin
                misalign_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            misalign_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            misalign_q <= misalign_d;
        end
    end

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: one memory read per start_fetch, with timeout fallback to NOP.
module unidade_busca
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_fetch,
    input  logic        load_PC,
    input  logic        sel_PC_src,
    input  logic [31:0] pc_target,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] instr,
    output logic [6:0]  opcode,
    output logic        fetch_done,
    output logic        fetch_timeout,
    output logic        misalign_err
);

    localparam int unsigned CNT_W   = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned TO_LAST = (TIMEOUT < 1) ? 0 : TIMEOUT - 1;

    fetch_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       instr_q, instr_d;
    logic              imem_req_q, imem_req_d;
    logic              fetch_done_q, fetch_done_d;
    logic              timeout_q, timeout_d;
    logic              pc_load_en_c;

    // PC may only move while no memory transaction is outstanding
    assign pc_load_en_c = load_PC && ((state_q == ST_IDLE) || (state_q == ST_DONE));

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk          (clk),
        .rst_n        (rst),
        .load_en      (pc_load_en_c),
        .sel_target   (sel_PC_src),
        .pc_target    (pc_target),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misalign_err (misalign_err)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        instr_d   = instr_q;
        timeout_d = timeout_q;
        unique case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (start_fetch) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(TO_LAST)) begin
                    instr_d   = INSTR_NOP;
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs registered from the upcoming state so they align with it
        imem_req_d   = (state_d == ST_REQ) || (state_d == ST_WAIT);
        fetch_done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            instr_q      <= INSTR_NOP;
            imem_req_q   <= 1'b0;
            fetch_done_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            instr_q      <= instr_d;
            imem_req_q   <= imem_req_d;
            fetch_done_q <= fetch_done_d;
            timeout_q    <= timeout_d;
        end
    end

    assign imem_req      = imem_req_q;
    assign fetch_done    = fetch_done_q;
    assign fetch_timeout = timeout_q;
    assign instr         = instr_q;
    assign opcode        = instr_q[6:0];
    assign imem_addr     = pc;

endmodule

// File: tb/tb_unidade_busca.sv
// Bench for unidade_busca: transaction-level reference model plus directed scenarios and random traffic.
module tb_unidade_busca;

    localparam int unsigned TO = 15;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        start_fetch;
    logic        load_PC;
    logic        sel_PC_src;
    logic [31:0] pc_target;
    logic [31:0] imem_rdata;
    logic        imem_ack;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
    logic [6:0]  opcode;
    logic        fetch_done;
    logic        fetch_timeout;
    logic        misalign_err;

    int vectors = 0;
    int miscompares = 0;

    unidade_busca #(
        .RESET_PC (RST_PC),
        .TIMEOUT  (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start_fetch   (start_fetch),
        .load_PC       (load_PC),
        .sel_PC_src    (sel_PC_src),
        .pc_target     (pc_target),
        .imem_rdata    (imem_rdata),
        .imem_ack      (imem_ack),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .instr         (instr),
        .opcode        (opcode),
        .fetch_done    (fetch_done),
        .fetch_timeout (fetch_timeout),
        .misalign_err  (misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a fetch is "busy" for the request plus its wait cycles,
    // then reports done for one cycle; the PC only moves when not busy.
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_cyc = 0;
    logic [31:0] m_pc = RST_PC;
    logic [31:0] m_ir = NOP;
    bit          m_to = 1'b0;
    bit          m_mis = 1'b0;
    logic [31:0] m_nxt;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_cyc  = 0;
            m_pc   = RST_PC;
            m_ir   = NOP;
            m_to   = 1'b0;
            m_mis  = 1'b0;
        end else begin
            if (!m_busy && load_PC) begin
                m_nxt = sel_PC_src ? pc_target : m_pc + 32'd4;
                if (m_nxt % 4 != 0) m_mis = 1'b1;
                else                m_pc  = m_nxt;
            end
            if (m_done) begin
                m_done = 1'b0;
            end else if (m_busy) begin
                if (imem_ack) begin
                    m_ir   = imem_rdata;
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else if (m_cyc == int'(TO)) begin
                    m_ir   = NOP;
                    m_to   = 1'b1;
                    m_busy = 1'b0;
                    m_done = 1'b1;
                end else begin
                    m_cyc++;
                end
            end else if (start_fetch) begin
                m_busy = 1'b1;
                m_cyc  = 0;
            end
        end
    end

    // Continuous comparison against the model on every falling edge out of reset
    always @(negedge clk) begin
        if (rst) begin
            check("imem_req",      32'(imem_req),      32'(m_busy));
            check("fetch_done",    32'(fetch_done),    32'(m_done));
            check("pc",            pc,                 m_pc);
            check("pc_plus4",      pc_plus4,           m_pc + 32'd4);
            check("imem_addr",     imem_addr,          m_pc);
            check("instr",         instr,              m_ir);
            check("opcode",        32'(opcode),        32'(m_ir[6:0]));
            check("fetch_timeout", 32'(fetch_timeout), 32'(m_to));
            check("misalign_err",  32'(misalign_err),  32'(m_mis));
        end
    end

    task automatic idle_inputs();
        start_fetch = 1'b0;
        load_PC     = 1'b0;
        sel_PC_src  = 1'b0;
        pc_target   = 32'h0;
        imem_rdata  = 32'h0;
        imem_ack    = 1'b0;
    endtask

    int req_cnt;
    int done_cnt;
    logic [31:0] addr0;
    bit seen;
    logic [31:0] r;
    int ack_pct;

    initial begin
        rst = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset values
        check("rst_pc",       pc, 32'h0);
        check("rst_instr",    instr, NOP);
        check("rst_opcode",   32'(opcode), 32'h13);
        check("rst_req",      32'(imem_req), 32'h0);
        check("rst_done",     32'(fetch_done), 32'h0);
        check("rst_timeout",  32'(fetch_timeout), 32'h0);
        check("rst_misalign", 32'(misalign_err), 32'h0);

        // Fastest fetch: ack in the request cycle
        start_fetch = 1'b1;
        @(negedge clk);
        start_fetch = 1'b0;
        check("fast_req", 32'(imem_req), 32'h1);
        imem_ack   = 1'b1;
        imem_rdata = 32'h0000_0033;
        @(negedge clk);
        imem_ack = 1'b0;
        check("fast_done",   32'(fetch_done), 32'h1);
        check("fast_opcode", 32'(opcode), 32'h33);
        check("fast_pc",     pc, 32'h0);
        @(negedge clk);
        check("fast_done_once", 32'(fetch_done), 32'h0);

        // Ack three cycles late
        start_fetch = 1'b1;
        @(negedge clk);
        start_fetch = 1'b0;
        addr0    = imem_addr;
        req_cnt  = 0;
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            req_cnt  += int'(imem_req);
            done_cnt += int'(fetch_done);
            if (imem_req) check("late_addr_stable", imem_addr, addr0);
            imem_ack   = (i == 3);
            imem_rdata = 32'h1234_5037;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        check("late_req_cycles", 32'(req_cnt), 32'd4);
        check("late_done_count", 32'(done_cnt), 32'd1);
        check("late_instr",      instr, 32'h1234_5037);

        // No ack: timeout after TO wait cycles
        start_fetch = 1'b1;
        @(negedge clk);
        start_fetch = 1'b0;
        req_cnt = 0;
        seen    = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            req_cnt += int'(imem_req);
            @(negedge clk);
            if (fetch_done) seen = 1'b1;
        end
        check("to_done_seen", 32'(seen), 32'h1);
        check("to_req_cycles", 32'(req_cnt), 32'd16);
        check("to_instr",      instr, 32'h0000_0013);
        check("to_flag",       32'(fetch_timeout), 32'h1);
        @(negedge clk);

        // Misaligned target rejected, aligned target accepted
        load_PC    = 1'b1;
        sel_PC_src = 1'b1;
        pc_target  = 32'h0000_0102;
        @(negedge clk);
        check("mis_pc",   pc, 32'h0);
        check("mis_flag", 32'(misalign_err), 32'h1);
        pc_target = 32'h0000_0100;
        @(negedge clk);
        load_PC = 1'b0;
        check("align_pc", pc, 32'h0000_0100);

        // Fetch from the new PC to give IR a non-NOP value
        start_fetch = 1'b1;
        @(negedge clk);
        start_fetch = 1'b0;
        check("pc100_addr", imem_addr, 32'h0000_0100);
        imem_ack   = 1'b1;
        imem_rdata = 32'h00A0_0093;
        @(negedge clk);
        imem_ack = 1'b0;
        check("pc100_instr", instr, 32'h00A0_0093);
        @(negedge clk);

        // Asynchronous reset in the middle of WAIT
        start_fetch = 1'b1;
        @(negedge clk);
        start_fetch = 1'b0;
        repeat (3) @(negedge clk);
        check("arst_pre_req", 32'(imem_req), 32'h1);
        #2 rst = 1'b0;
        #1;
        check("arst_req",      32'(imem_req), 32'h0);
        check("arst_done",     32'(fetch_done), 32'h0);
        check("arst_instr",    instr, NOP);
        check("arst_pc",       pc, RST_PC);
        check("arst_timeout",  32'(fetch_timeout), 32'h0);
        check("arst_misalign", 32'(misalign_err), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        // No fetch without a fresh start_fetch
        repeat (3) @(negedge clk);
        check("post_rst_idle", 32'(imem_req), 32'h0);

        // PC wraps past the top of the address space
        load_PC    = 1'b1;
        sel_PC_src = 1'b1;
        pc_target  = 32'hFFFF_FFFC;
        @(negedge clk);
        sel_PC_src = 1'b0;
        @(negedge clk);
        load_PC = 1'b0;
        check("wrap_pc",       pc, 32'h0);
        check("wrap_misalign", 32'(misalign_err), 32'h0);

        // Random traffic in three ack-probability regimes
        for (int blk = 0; blk < 3; blk++) begin
            ack_pct = (blk == 0) ? 60 : (blk == 1) ? 15 : 0;
            for (int c = 0; c < 1000; c++) begin
                start_fetch = ($urandom % 3) == 0;
                load_PC     = ($urandom % 5) == 0;
                sel_PC_src  = ($urandom % 2) == 1;
                r = $urandom;
                if (($urandom % 16) == 0)      pc_target = r;
                else if (($urandom % 32) == 0) pc_target = 32'hFFFF_FFFC;
                else                           pc_target = {r[31:2], 2'b00};
                imem_rdata = $urandom;
                imem_ack   = int'($urandom % 100) < ack_pct;
                @(negedge clk);
            end
            if (blk == 1) begin
                // Clear sticky flags so later regimes exercise them afresh
                idle_inputs();
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
            end
        end
        idle_inputs();
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
